// File: rtl/rx_lane_deskew_packer.sv
// rtl/rx_lane_deskew_packer.sv - 4-lane sync-byte aligner, deskew FIFOs and 32-bit repacker (option macro: RX_SYNC_1BIT_ERR_EN)
module rx_lane_deskew_packer #(
  parameter int SKEW_DEPTH = 4,
  parameter int SKEW_MAX   = 3
) (
  input  logic        clk_s,
  input  logic        reset,
  input  logic        hsxx_clk_en,
  input  logic [31:0] lane_data,
  output logic [31:0] dataout,
  output logic        data_valid,
  output logic        rx_ready,
  output logic        sync_err
);
  localparam int PW = (SKEW_DEPTH > 1) ? $clog2(SKEW_DEPTH) : 1;
  localparam int CW = $clog2(SKEW_DEPTH + 1);
  localparam int SW = (SKEW_MAX > 0) ? $clog2(SKEW_MAX + 1) : 1;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {IDLE, HUNT, ALIGN, STREAM, ERROR} state_t;
  state_t state, state_nxt;

  logic [7:0]    prev_q   [4];
  logic [2:0]    offset_q [4];
  logic [3:0]    lane_sync;
  logic [SW-1:0] skew_cnt;
  logic [7:0]    fifo_mem [4][SKEW_DEPTH];
  logic [PW-1:0] wr_ptr   [4];
  logic [PW-1:0] rd_ptr   [4];
  logic [CW-1:0] fifo_cnt [4];

  logic [15:0] win      [4];
  logic [3:0]  sync_res [4];
  logic [7:0]  cand     [4];
  logic [3:0]  hit, full, nonempty, lane_wr, lane_drop;
  logic        hunting, pop, align_fail;

  // Returns {found, k}: lowest exact match wins; optionally falls back to lowest 1-bit match.
  function automatic logic [3:0] find_sync(input logic [15:0] w);
    logic [3:0] r;
    r = 4'd0;
`ifdef RX_SYNC_1BIT_ERR_EN
    for (int k = 7; k >= 0; k--) begin
      logic [7:0] x;
      x = w[k +: 8] ^ SYNC_BYTE;
      if ((x & (x - 8'd1)) == 8'd0) r = {1'b1, 3'(k)};
    end
`endif
    for (int k = 7; k >= 0; k--) begin
      if (w[k +: 8] == SYNC_BYTE) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  assign hunting  = hsxx_clk_en && (state == HUNT || state == ALIGN);
  assign rx_ready = (state == STREAM);

  // Per-lane 16-bit window, sync search and byte extraction at the frozen offset.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      win[i]      = {lane_data[8*i +: 8], prev_q[i]};
      sync_res[i] = find_sync(win[i]);
      hit[i]      = hunting && !lane_sync[i] && sync_res[i][3];
      cand[i]     = win[i][offset_q[i] +: 8];
      full[i]     = (fifo_cnt[i] == CW'(SKEW_DEPTH));
      nonempty[i] = (fifo_cnt[i] != '0);
    end
  end

  // Next state plus FIFO write/pop strobes.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    lane_wr    = '0;
    lane_drop  = '0;
    align_fail = 1'b0;
    if (!hsxx_clk_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = HUNT;
        HUNT:    if (|hit) state_nxt = ALIGN;
        ALIGN: begin
          if (&lane_sync) begin
            state_nxt = STREAM;
          end else if (int'(skew_cnt) >= SKEW_MAX) begin
            state_nxt  = ERROR;
            align_fail = 1'b1;
          end
        end
        default: state_nxt = state;
      endcase
      pop = (state == STREAM) && (&nonempty);
      for (int i = 0; i < 4; i++) begin
        if (lane_sync[i] && (state == ALIGN || state == STREAM)) begin
          if (!full[i] || pop) lane_wr[i] = 1'b1;
          else                 lane_drop[i] = 1'b1;
        end
      end
    end
  end

  // State register and skew counter; the counter runs only while waiting in ALIGN.
  always_ff @(posedge clk_s) begin
    if (reset) begin
      state    <= IDLE;
      skew_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skew_cnt <= (state == ALIGN && state_nxt == ALIGN) ? skew_cnt + SW'(1) : '0;
    end
  end

  // Previous-byte registers, lane sync flags and frozen offsets; cleared whenever the burst ends.
  always_ff @(posedge clk_s) begin
    if (reset || !hsxx_clk_en) begin
      lane_sync <= '0;
      for (int i = 0; i < 4; i++) begin
        prev_q[i]   <= 8'd0;
        offset_q[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        prev_q[i] <= lane_data[8*i +: 8];
        if (hit[i]) begin
          lane_sync[i] <= 1'b1;
          offset_q[i]  <= sync_res[i][2:0];
        end
      end
    end
  end

  // Deskew FIFO storage; early lanes accumulate bytes until the last lane catches up.
  always_ff @(posedge clk_s) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_wr[i]) fifo_mem[i][wr_ptr[i]] <= cand[i];
    end
  end

  // Deskew FIFO pointers and occupancy; all lanes pop together.
  always_ff @(posedge clk_s) begin
    if (reset || !hsxx_clk_en) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        fifo_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_wr[i])
          wr_ptr[i] <= (wr_ptr[i] == PW'(SKEW_DEPTH - 1)) ? '0 : wr_ptr[i] + PW'(1);
        if (pop)
          rd_ptr[i] <= (rd_ptr[i] == PW'(SKEW_DEPTH - 1)) ? '0 : rd_ptr[i] + PW'(1);
        fifo_cnt[i] <= fifo_cnt[i] + CW'(lane_wr[i]) - CW'(pop);
      end
    end
  end

  // Registered output word, valid strobe and error pulse.
  always_ff @(posedge clk_s) begin
    if (reset) begin
      dataout    <= 32'd0;
      data_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      data_valid <= pop;
      sync_err   <= align_fail || (|lane_drop);
      if (pop) begin
        for (int i = 0; i < 4; i++) dataout[8*i +: 8] <= fifo_mem[i][rd_ptr[i]];
      end
    end
  end
endmodule

// File: tb/tb_rx_lane_deskew_packer.sv
// tb/tb_rx_lane_deskew_packer.sv - self-checking bench for rx_lane_deskew_packer
module tb_rx_lane_deskew_packer;
  localparam int SKEW_MAX = 3;
  localparam int NPAY = 16;
  localparam int NB = 512;
  localparam logic [7:0] SYNC = 8'hB8;

  logic        clk_s = 1'b0;
  logic        reset = 1'b1;
  logic        hsxx_clk_en = 1'b0;
  logic [31:0] lane_data = 32'd0;
  logic [31:0] dataout;
  logic        data_valid, rx_ready, sync_err;

  rx_lane_deskew_packer #(.SKEW_DEPTH(4), .SKEW_MAX(SKEW_MAX)) dut (
    .clk_s(clk_s), .reset(reset), .hsxx_clk_en(hsxx_clk_en), .lane_data(lane_data),
    .dataout(dataout), .data_valid(data_valid), .rx_ready(rx_ready), .sync_err(sync_err)
  );

  always #5 clk_s = ~clk_s;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  logic        e_valid = 1'b0, e_ready = 1'b0, e_err = 1'b0, e_chk_data = 1'b1;
  logic [31:0] e_data = 32'd0;

  bit         stream  [4][NB];
  int         sc_s    [4];
  int         sc_d    [4];
  logic [7:0] sc_sync [4];
  logic [7:0] payload [4][NPAY];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sync_ok(input logic [7:0] b);
`ifdef RX_SYNC_1BIT_ERR_EN
    return $countones(b ^ SYNC) <= 1;
`else
    return b == SYNC;
`endif
  endfunction

  function automatic logic [7:0] stream_byte(input int lane, input int pos);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = (pos + b < NB) ? stream[lane][pos + b] : 1'b0;
    return v;
  endfunction

  // Compare process: DUT outputs against the model one time unit after each active edge.
  always @(posedge clk_s) begin
    #1;
    if (armed) begin
      chk("data_valid", {31'd0, data_valid}, {31'd0, e_valid});
      chk("rx_ready",   {31'd0, rx_ready},   {31'd0, e_ready});
      chk("sync_err",   {31'd0, sync_err},   {31'd0, e_err});
      if (e_valid || e_chk_data) chk("dataout", dataout, e_data);
    end
  end

  // Builds serial lane streams (zeros, pre+s byte times plus d bits, sync byte, payload, zeros),
  // predicts outputs from sync edges: lane syncs at edge pre+s+2, words flow from latest sync + 2.
  task automatic run_scenario(input int pre, input int ncyc, input int end_mode, input int pin);
    int p [4];
    int lsync, lmax, e0;
    bit ok, any;
    logic [31:0] ld, w;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < NB; b++) stream[i][b] = 1'b0;
      p[i] = 8 * (pre + sc_s[i]) + sc_d[i];
      for (int b = 0; b < 8; b++) stream[i][p[i] + b] = sc_sync[i][b];
      for (int j = 0; j < NPAY; j++)
        for (int b = 0; b < 8; b++) stream[i][p[i] + 8 + 8*j + b] = payload[i][j][b];
    end
    ok = 1'b1; any = 1'b0; lmax = 0; e0 = 1000000;
    for (int i = 0; i < 4; i++) begin
      if (sync_ok(sc_sync[i])) begin
        lsync = pre + sc_s[i] + 2;
        any = 1'b1;
        if (lsync < e0) e0 = lsync;
        if (lsync > lmax) lmax = lsync;
      end else begin
        ok = 1'b0;
      end
    end
    if (!any || (lmax - e0) > SKEW_MAX) ok = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk_s);
      for (int i = 0; i < 4; i++) ld[8*i +: 8] = stream_byte(i, 8 * (c - 1));
      reset = 1'b0;
      hsxx_clk_en = 1'b1;
      lane_data = ld;
      e_chk_data = 1'b0;
      e_ready = ok && (c >= lmax + 1);
      e_valid = ok && (c >= lmax + 2);
      w = 32'd0;
      if (e_valid)
        for (int i = 0; i < 4; i++) w[8*i +: 8] = stream_byte(i, p[i] + 8 + 8 * (c - lmax - 2));
      e_data = w;
      e_err = !ok && any && (c == e0 + SKEW_MAX + 1);
      if (pin == 1 && c == 12) chk("model_ready_t12", {31'd0, e_ready}, 32'd1);
      if (pin == 1 && c == 13) chk("model_word_t13", e_data, 32'h03020100);
      if (pin == 1 && c == 14) chk("model_word_t14", e_data, 32'h07060504);
      if (pin == 2 && c == 8)  chk("model_err_t8", {31'd0, e_err}, 32'd1);
      if (pin == 3 && c == 7)  chk("model_shift_word", e_data, 32'h03020100);
    end
    @(negedge clk_s);
    lane_data = 32'd0;
    if (end_mode == 1) reset = 1'b1;
    else hsxx_clk_en = 1'b0;
    e_valid = 1'b0; e_ready = 1'b0; e_err = 1'b0;
    e_data = 32'd0;
    e_chk_data = (end_mode == 1);
  endtask

  task automatic set_default();
    for (int i = 0; i < 4; i++) begin
      sc_s[i] = 0;
      sc_d[i] = 0;
      sc_sync[i] = SYNC;
      for (int j = 0; j < NPAY; j++) payload[i][j] = 8'(4 * j + i);
    end
  endtask

  initial begin
    int pre, mx, nc;
    @(negedge clk_s);
    armed = 1'b1;
    repeat (3) @(negedge clk_s);

    set_default();
    run_scenario(9, 16, 0, 1);
    set_default(); sc_d[2] = 5;
    run_scenario(3, 12, 0, 3);
    set_default(); sc_s[3] = 3;
    run_scenario(2, 14, 0, 0);
    set_default(); sc_s[3] = 4;
    run_scenario(2, 14, 0, 2);
    set_default(); sc_sync[1] = 8'hB9; payload[1][0] = 8'h00;
    run_scenario(2, 14, 0, 0);
    set_default(); sc_s[0] = 2; sc_d[1] = 3;
    run_scenario(1, 12, 1, 0);
    set_default(); sc_s[2] = 1; sc_d[3] = 7;
    run_scenario(1, 12, 0, 0);

    for (int r = 0; r < 24; r++) begin
      pre = $urandom_range(1, 3);
      mx = 0;
      for (int i = 0; i < 4; i++) begin
        sc_s[i] = $urandom_range(0, (r % 3 == 0) ? 4 : 3);
        sc_d[i] = $urandom_range(0, 7);
        sc_sync[i] = SYNC;
        if (sc_s[i] > mx) mx = sc_s[i];
        for (int j = 0; j < NPAY; j++) payload[i][j] = 8'($urandom);
      end
      nc = pre + mx + $urandom_range(6, 12);
      run_scenario(pre, nc, $urandom_range(0, 1), 0);
    end

    @(negedge clk_s);
    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
